// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder stage walks the operands LSB first,
// taking WIDTH cycles per operation, with results held stable between operations.
module serial_add_ctrl #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, shift_reg, sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg, cout_reg, ovf_reg;

    logic             fa_sum, fa_carry, last_bit;

    // The single full-adder stage shared by every bit position.
    assign fa_sum   = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign fa_carry = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
    assign last_bit = (state_reg == RUN) && (cnt_reg == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            shift_reg <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1, so invert B and force the carry.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    shift_reg <= {fa_sum, shift_reg[WIDTH-1:1]};
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= fa_carry;
                    if (last_bit) begin
                        // carry_reg here is the carry into the MSB.
                        sum_reg  <= {fa_sum, shift_reg[WIDTH-1:1]};
                        cout_reg <= fa_carry;
                        ovf_reg  <= carry_reg ^ fa_carry;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8: arithmetic cases, latency,
// start masking while busy, asynchronous reset abort and back-to-back operation.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks;
    int errors;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present operands for one rising edge, returning at the negedge after it.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_op,
                          input logic tsub, input logic tcin);
        @(negedge clk);
        a = ta; b = tb_op; sub = tsub; cin = tcin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observe negedges until done; lat counts negedges after the one following E0.
    task automatic wait_done(input logic [W-1:0] prev, output int lat, output bit held);
        lat  = -1;
        held = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (sum !== prev) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        int lat;
        bit held;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #12;
        checks++;
        if ({busy, done, sum, cout, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'h03; b = 8'h04; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_edge_start got busy=%b want 1", busy);
        end
        wait_done(8'h00, lat, held);
        checks++;
        if (lat !== 8 || sum !== 8'h07) begin
            errors++;
            $display("FAIL first_edge_result got lat=%0d sum=%h want lat=8 sum=07", lat, sum);
        end
        $display("reset/first op: 03+04 sum=%h lat=%0d", sum, lat);
        @(negedge clk);
    endtask

    task automatic test_arith();
        logic [W-1:0] va [5] = '{8'h7F, 8'hFF, 8'h00, 8'h05, 8'h80};
        logic [W-1:0] vb [5] = '{8'h01, 8'h01, 8'h00, 8'h07, 8'h01};
        logic         vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] es [5] = '{8'h80, 8'h00, 8'h01, 8'hFE, 8'h7F};
        logic         eco[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic         eov[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] prev;
        int lat;
        bit held;
        for (int i = 0; i < 5; i++) begin
            prev = sum;
            launch(va[i], vb[i], vs[i], vc[i]);
            wait_done(prev, lat, held);
            $display("op %0d: a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                     i, va[i], vb[i], vs[i], vc[i], sum, cout, ovf, lat);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL arith_latency[%0d] got %0d want 8", i, lat);
            end
            checks++;
            if ({sum, cout, ovf} !== {es[i], eco[i], eov[i]}) begin
                errors++;
                $display("FAIL arith_result[%0d] got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, sum, cout, ovf, es[i], eco[i], eov[i]);
            end
            checks++;
            if (!held) begin
                errors++;
                $display("FAIL arith_hold[%0d] sum changed during RUN, want held at %h", i, prev);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || sum !== es[i]) begin
                errors++;
                $display("FAIL arith_pulse[%0d] got done=%b sum=%h want done=0 sum=%h",
                         i, done, sum, es[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int lat;
        bit held;
        launch(8'h55, 8'h0F, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d done pulses want 0", dones);
        end
        launch(8'h10, 8'h20, 1'b0, 1'b0);
        wait_done(8'h00, lat, held);
        $display("after abort: 10+20 sum=%h lat=%0d", sum, lat);
        checks++;
        if (lat !== 8 || sum !== 8'h30 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_op got lat=%0d sum=%h cout=%b ovf=%b want lat=8 sum=30 cout=0 ovf=0",
                     lat, sum, cout, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int busy_cnt = 0;
        int done_at = -1;
        int dones = 0;
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                dones++;
                done_at = i;
            end
            start = 1'b0;
            if (i == 2 || done) begin
                a = 8'hFF; b = 8'hFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        $display("ignore start: 12+34 sum=%h busy_cycles=%0d done_at=%0d", sum, busy_cnt, done_at);
        checks++;
        if (busy_cnt !== 9) begin
            errors++;
            $display("FAIL busy_cycles got %0d want 9", busy_cnt);
        end
        checks++;
        if (dones !== 1 || done_at !== 8) begin
            errors++;
            $display("FAIL ignore_done got %0d pulses at %0d want 1 at 8", dones, done_at);
        end
        checks++;
        if ({sum, cout, ovf, busy} !== {8'h46, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ignore_result got sum=%h cout=%b ovf=%b busy=%b want sum=46 cout=0 ovf=0 busy=0",
                     sum, cout, ovf, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [3] = '{8'h01, 8'h40, 8'hF0};
        logic [W-1:0] vb [3] = '{8'h02, 8'h40, 8'h20};
        logic [W-1:0] es [3] = '{8'h03, 8'h80, 8'h10};
        logic         eco[3] = '{1'b0, 1'b0, 1'b1};
        logic         eov[3] = '{1'b0, 1'b1, 1'b0};
        int           at  [3] = '{-1, -1, -1};
        logic [W+1:0] cap;
        int k = 0;
        int unstable = 0;
        @(negedge clk);
        a = va[0]; b = vb[0]; sub = 1'b0; cin = 1'b0; start = 1'b1;
        cap = {sum, cout, ovf};
        for (int i = 0; i < 60 && k < 3; i++) begin
            @(negedge clk);
            if (done) begin
                at[k] = i;
                cap = {sum, cout, ovf};
                $display("b2b op %0d: sum=%h cout=%b ovf=%b at cycle %0d", k, sum, cout, ovf, i);
                checks++;
                if (cap !== {es[k], eco[k], eov[k]}) begin
                    errors++;
                    $display("FAIL b2b_result[%0d] got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                             k, sum, cout, ovf, es[k], eco[k], eov[k]);
                end
                k++;
                if (k < 3) begin
                    a = va[k]; b = vb[k];
                end else begin
                    start = 1'b0;
                end
            end else if ({sum, cout, ovf} !== cap) begin
                unstable++;
            end
        end
        start = 1'b0;
        checks++;
        if (at[1] - at[0] !== 10 || at[2] - at[1] !== 10) begin
            errors++;
            $display("FAIL b2b_spacing got pulses at %0d,%0d,%0d want 10 apart", at[0], at[1], at[2]);
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL b2b_stable got %0d changes between pulses want 0", unstable);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop got busy=%b want 0 after start dropped", busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_arith();
        test_reset_mid();
        test_ignore_start();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
